// File: rtl/regfile_mp.sv
// Multi-read-port register file (r0 hardwired to zero) with write-through bypass and per-register busy scoreboard.
// Reads are combinational, or registered with one cycle of latency when REG_READ=1. There is no backpressure: one write, one issue and one read per port every cycle.
module regfile_mp #(
  parameter int NUM_REGS     = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_READ     = 2,
  parameter int REG_READ     = 0,
  parameter int WRITE_BYPASS = 1,
  localparam int ADDR_W      = $clog2(NUM_REGS)
) (
  input  logic                           clock,
  input  logic                           ctrl_reset,
  input  logic                           ctrl_writeEnable,
  input  logic [ADDR_W-1:0]              ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0]          data_writeReg,
  input  logic                           ctrl_issue,
  input  logic [ADDR_W-1:0]              ctrl_issueReg,
  input  logic [NUM_READ*ADDR_W-1:0]     ctrl_readReg,
  output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
  output logic [NUM_READ-1:0]            read_busy,
  output logic [NUM_REGS-1:0]            busy_vec
);

  logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_nxt;
  logic                  wr_hit;

  // Writes are neither stored nor forwarded while reset is held.
  assign wr_hit = ctrl_writeEnable && ctrl_reset && (ctrl_writeReg != '0);

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      for (int r = 1; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (wr_hit) begin
      regs[ctrl_writeReg] <= data_writeReg;
    end
  end

  // Issue is applied after the write clear so a new producer wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_hit) busy_nxt[ctrl_writeReg] = 1'b0;
    if (ctrl_issue && (ctrl_issueReg != '0)) busy_nxt[ctrl_issueReg] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) busy <= '0;
    else             busy <= busy_nxt;
  end

  assign busy_vec = busy;

  for (genvar p = 0; p < NUM_READ; p++) begin : g_port
    logic [ADDR_W-1:0]     addr;
    logic                  byp;
    logic [DATA_WIDTH-1:0] rd_c;
    logic                  rb_c;

    assign addr = ctrl_readReg[p*ADDR_W +: ADDR_W];
    assign byp  = (WRITE_BYPASS != 0) && wr_hit && (ctrl_writeReg == addr);
    assign rd_c = (addr == '0) ? '0 : (byp ? data_writeReg : regs[addr]);
    assign rb_c = (addr != '0) && !byp && busy[addr];

    if (REG_READ != 0) begin : g_reg
      logic [DATA_WIDTH-1:0] rd_q;
      logic                  rb_q;

      always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
          rd_q <= '0;
          rb_q <= 1'b0;
        end else begin
          rd_q <= rd_c;
          rb_q <= rb_c;
        end
      end

      assign data_readReg[p*DATA_WIDTH +: DATA_WIDTH] = rd_q;
      assign read_busy[p]                             = rb_q;
    end else begin : g_comb
      assign data_readReg[p*DATA_WIDTH +: DATA_WIDTH] = rd_c;
      assign read_busy[p]                             = rb_c;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three 32x32 variants share one stimulus stream, plus a 16x8 four-port variant.
// All variants are checked every cycle against an array model of registers and busy bits.
module tb_regfile_mp;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        ctrl_reset;
  logic        we, iss;
  logic [4:0]  wr, ir;
  logic [31:0] wd;
  logic [9:0]  rr;

  logic [63:0] a_rd, b_rd, c_rd;
  logic [1:0]  a_rb, b_rb, c_rb;
  logic [31:0] a_bv, b_bv, c_bv;

  logic        s_we, s_iss;
  logic [3:0]  s_wr, s_ir;
  logic [7:0]  s_wd;
  logic [15:0] s_rr;
  logic [31:0] s_rd;
  logic [3:0]  s_rb;
  logic [15:0] s_bv;

  regfile_mp #(.NUM_REGS(32), .DATA_WIDTH(32), .NUM_READ(2), .REG_READ(0), .WRITE_BYPASS(1)) u_a (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(we), .ctrl_writeReg(wr),
    .data_writeReg(wd), .ctrl_issue(iss), .ctrl_issueReg(ir), .ctrl_readReg(rr),
    .data_readReg(a_rd), .read_busy(a_rb), .busy_vec(a_bv));

  regfile_mp #(.NUM_REGS(32), .DATA_WIDTH(32), .NUM_READ(2), .REG_READ(0), .WRITE_BYPASS(0)) u_b (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(we), .ctrl_writeReg(wr),
    .data_writeReg(wd), .ctrl_issue(iss), .ctrl_issueReg(ir), .ctrl_readReg(rr),
    .data_readReg(b_rd), .read_busy(b_rb), .busy_vec(b_bv));

  regfile_mp #(.NUM_REGS(32), .DATA_WIDTH(32), .NUM_READ(2), .REG_READ(1), .WRITE_BYPASS(1)) u_c (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(we), .ctrl_writeReg(wr),
    .data_writeReg(wd), .ctrl_issue(iss), .ctrl_issueReg(ir), .ctrl_readReg(rr),
    .data_readReg(c_rd), .read_busy(c_rb), .busy_vec(c_bv));

  regfile_mp #(.NUM_REGS(16), .DATA_WIDTH(8), .NUM_READ(4), .REG_READ(0), .WRITE_BYPASS(1)) u_s (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(s_we), .ctrl_writeReg(s_wr),
    .data_writeReg(s_wd), .ctrl_issue(s_iss), .ctrl_issueReg(s_ir), .ctrl_readReg(s_rr),
    .data_readReg(s_rd), .read_busy(s_rb), .busy_vec(s_bv));

  // Reference model: plain arrays of register values and busy flags.
  logic [31:0] mem   [32];
  logic        mbusy [32];
  logic [7:0]  smem  [16];
  logic        sbusy [16];
  logic [31:0] c_d   [2];
  logic        c_b   [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_data(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && we && ctrl_reset && wr != 5'd0 && wr == a) return wd;
    return mem[a];
  endfunction

  function automatic logic m_busy(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 1'b0;
    if (byp && we && ctrl_reset && wr != 5'd0 && wr == a) return 1'b0;
    return mbusy[a];
  endfunction

  function automatic logic [7:0] s_data(input logic [3:0] a);
    if (a == 4'd0) return 8'd0;
    if (s_we && ctrl_reset && s_wr != 4'd0 && s_wr == a) return s_wd;
    return smem[a];
  endfunction

  function automatic logic s_busyf(input logic [3:0] a);
    if (a == 4'd0) return 1'b0;
    if (s_we && ctrl_reset && s_wr != 4'd0 && s_wr == a) return 1'b0;
    return sbusy[a];
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 32; r++) begin mem[r] = 32'd0; mbusy[r] = 1'b0; end
    for (int r = 0; r < 16; r++) begin smem[r] = 8'd0; sbusy[r] = 1'b0; end
    for (int p = 0; p < 2; p++) begin c_d[p] = 32'd0; c_b[p] = 1'b0; end
  endtask

  task automatic check_all();
    logic [31:0] ev;
    logic [15:0] sev;
    logic [4:0]  a;
    logic [3:0]  sa;
    for (int p = 0; p < 2; p++) begin
      a = rr[p*5 +: 5];
      chk($sformatf("a_rd%0d", p), a_rd[p*32 +: 32], m_data(a, 1'b1));
      chk($sformatf("a_rb%0d", p), 32'(a_rb[p]), 32'(m_busy(a, 1'b1)));
      chk($sformatf("b_rd%0d", p), b_rd[p*32 +: 32], m_data(a, 1'b0));
      chk($sformatf("b_rb%0d", p), 32'(b_rb[p]), 32'(m_busy(a, 1'b0)));
      chk($sformatf("c_rd%0d", p), c_rd[p*32 +: 32], c_d[p]);
      chk($sformatf("c_rb%0d", p), 32'(c_rb[p]), 32'(c_b[p]));
    end
    for (int r = 0; r < 32; r++) ev[r] = mbusy[r];
    chk("a_bv", a_bv, ev);
    chk("b_bv", b_bv, ev);
    chk("c_bv", c_bv, ev);
    for (int p = 0; p < 4; p++) begin
      sa = s_rr[p*4 +: 4];
      chk($sformatf("s_rd%0d", p), 32'(s_rd[p*8 +: 8]), 32'(s_data(sa)));
      chk($sformatf("s_rb%0d", p), 32'(s_rb[p]), 32'(s_busyf(sa)));
    end
    for (int r = 0; r < 16; r++) sev[r] = sbusy[r];
    chk("s_bv", 32'(s_bv), 32'(sev));
  endtask

  task automatic sample();
    @(negedge clock);
    check_all();
  endtask

  task automatic tick();
    logic [31:0] nd [2];
    logic        nb [2];
    for (int p = 0; p < 2; p++) begin
      nd[p] = m_data(rr[p*5 +: 5], 1'b1);
      nb[p] = m_busy(rr[p*5 +: 5], 1'b1);
    end
    @(posedge clock);
    if (ctrl_reset) begin
      for (int p = 0; p < 2; p++) begin c_d[p] = nd[p]; c_b[p] = nb[p]; end
      if (we && wr != 5'd0) begin mem[wr] = wd; mbusy[wr] = 1'b0; end
      if (iss && ir != 5'd0) mbusy[ir] = 1'b1;
      if (s_we && s_wr != 4'd0) begin smem[s_wr] = s_wd; sbusy[s_wr] = 1'b0; end
      if (s_iss && s_ir != 4'd0) sbusy[s_ir] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    we = 1'b0; wr = 5'd0; wd = 32'd0; iss = 1'b0; ir = 5'd0;
    s_we = 1'b0; s_wr = 4'd0; s_wd = 8'd0; s_iss = 1'b0; s_ir = 4'd0;
  endtask

  // Reset is asserted between edges and checked before any edge arrives.
  task automatic do_reset();
    ctrl_reset = 1'b0;
    #1;
    clear_model();
    check_all();
    chk("rst_a_rd0", a_rd[31:0], 32'd0);
    chk("rst_c_rd0", c_rd[31:0], 32'd0);
    chk("rst_a_bv", a_bv, 32'd0);
    @(posedge clock);
    #1;
    ctrl_reset = 1'b1;
  endtask

  initial begin
    idle();
    rr = 10'd0;
    s_rr = 16'd0;
    ctrl_reset = 1'b0;
    clear_model();
    #2;
    check_all();
    chk("init_bv", a_bv, 32'd0);
    @(posedge clock);
    #1;
    ctrl_reset = 1'b1;

    // Preload r5, issue r7, then reset mid-cycle.
    we = 1'b1; wr = 5'd5; wd = 32'hDEADBEEF; iss = 1'b1; ir = 5'd7;
    sample(); tick();
    idle(); rr = {5'd7, 5'd5};
    sample();
    chk("pre_r5", a_rd[31:0], 32'hDEADBEEF);
    chk("pre_busy7", 32'(a_rb[1]), 32'd1);
    do_reset();

    // Write then read on both ports; r3 also drives the registered-read timing.
    we = 1'b1; wr = 5'd3; wd = 32'h12345678; rr = 10'd0;
    sample(); tick();
    idle(); rr = {5'd3, 5'd3};
    sample();
    chk("rd_p0_r3", a_rd[31:0], 32'h12345678);
    chk("rd_p1_r3", a_rd[63:32], 32'h12345678);
    tick();
    rr = 10'd0;
    sample();
    chk("regrd_n1", c_rd[31:0], 32'h12345678);
    tick();
    sample();
    chk("regrd_n2", c_rd[31:0], 32'd0);
    tick();

    // Writes to r0 are discarded.
    we = 1'b1; wr = 5'd0; wd = 32'hFFFFFFFF; rr = 10'd0;
    sample();
    chk("r0_byp", a_rd[31:0], 32'd0);
    tick();
    idle();
    sample();
    chk("r0_rd", a_rd[31:0], 32'd0);
    tick();

    // Same-cycle bypass versus no bypass.
    we = 1'b1; wr = 5'd9; wd = 32'hA5A5A5A5; rr = {5'd9, 5'd9};
    sample();
    chk("byp_on", a_rd[31:0], 32'hA5A5A5A5);
    chk("byp_off", b_rd[31:0], 32'd0);
    tick();

    // Scoreboard set, clear, issue-wins, r0 ignored.
    idle(); iss = 1'b1; ir = 5'd4; rr = {5'd4, 5'd4};
    sample();
    chk("sb_pre", 32'(a_rb[0]), 32'd0);
    tick();
    idle();
    sample();
    chk("sb_set", 32'(a_rb[0]), 32'd1);
    chk("sb_vec4", 32'(a_bv[4]), 32'd1);
    tick();
    we = 1'b1; wr = 5'd4; wd = 32'h1;
    sample();
    chk("sb_byp_clr", 32'(a_rb[0]), 32'd0);
    chk("sb_nobyp", 32'(b_rb[0]), 32'd1);
    tick();
    idle();
    sample();
    chk("sb_clr", 32'(a_bv[4]), 32'd0);
    tick();
    we = 1'b1; wr = 5'd4; wd = 32'h2; iss = 1'b1; ir = 5'd4;
    sample(); tick();
    idle();
    sample();
    chk("sb_issue_wins", 32'(a_bv[4]), 32'd1);
    tick();
    iss = 1'b1; ir = 5'd0;
    sample(); tick();
    idle();
    sample();
    chk("sb_r0", 32'(a_bv[0]), 32'd0);
    tick();

    // 16x8 four-port variant.
    s_we = 1'b1; s_wr = 4'd15; s_wd = 8'h7F;
    sample(); tick();
    idle(); s_rr = {4{4'd15}};
    sample();
    for (int p = 0; p < 4; p++) chk($sformatf("sweep_p%0d", p), 32'(s_rd[p*8 +: 8]), 32'h7F);
    tick();

    // Randomised traffic, biased to a few registers for collisions, with one mid-run reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      we  = 1'($urandom_range(0, 1));
      iss = 1'($urandom_range(0, 1));
      wr  = (i % 4 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ir  = 5'($urandom_range(0, 7));
      wd  = $urandom;
      rr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      s_we  = 1'($urandom_range(0, 1));
      s_iss = 1'($urandom_range(0, 1));
      s_wr  = 4'($urandom_range(0, 15));
      s_ir  = 4'($urandom_range(0, 15));
      s_wd  = 8'($urandom);
      s_rr  = 16'($urandom);
      sample();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
